// File: rtl/enoc_core_interface_if.sv
// Packet format and the core/router port bundle for the node's core interface.
// The DUT takes the slave view; a core/router model (or bench) takes the master view.
package enoc_pkg;
   localparam int DEST_W = 4;

   typedef struct packed {
      logic [DEST_W-1:0] dest;
      logic [DEST_W-1:0] src;
      logic [23:0]       payload;
   } packet_t;
endpackage

interface enoc_core_interface_if #(parameter int CNT_W = 32);
   // Handshake on every port pair: a packet moves on the rising edge where its
   // valid and the receiver's enable are both high; valid never depends on enable.
   enoc_pkg::packet_t i_core_data;
   logic              i_core_data_val;
   logic              o_core_en;
   enoc_pkg::packet_t o_net_data;
   logic              o_net_data_val;
   logic              i_net_en;
   enoc_pkg::packet_t i_net_data;
   logic              i_net_data_val;
   logic              o_net_en;
   enoc_pkg::packet_t o_core_data;
   logic              o_core_data_val;
   logic              i_core_en;
   logic [CNT_W-1:0]  o_inj_count;
   logic [CNT_W-1:0]  o_ej_count;
   logic              o_overflow;
   logic              o_misroute;

   modport slave (
      input  i_core_data, i_core_data_val, i_net_en, i_net_data, i_net_data_val, i_core_en,
      output o_core_en, o_net_data, o_net_data_val, o_net_en, o_core_data, o_core_data_val,
             o_inj_count, o_ej_count, o_overflow, o_misroute
   );

   modport master (
      output i_core_data, i_core_data_val, i_net_en, i_net_data, i_net_data_val, i_core_en,
      input  o_core_en, o_net_data, o_net_data_val, o_net_en, o_core_data, o_core_data_val,
             o_inj_count, o_ej_count, o_overflow, o_misroute
   );
endinterface

// File: rtl/enoc_core_interface.sv
// Core-side network interface: FWFT injection queue toward the router and a
// single-entry ejection register toward the core, with traffic counters and sticky error flags.
module enoc_core_interface #(
   parameter int NODES = 16,
   parameter int LOC   = 0,
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input logic              clk,
   input logic              reset_n,
   enoc_core_interface_if.slave bus
);
   import enoc_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [DEST_W-1:0] LOC_ADDR = DEST_W'(LOC % NODES);

   packet_t          mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             empty;
   logic             wr_en;
   logic             rd_en;

   packet_t          ej_data;
   logic             ej_val;
   logic             ej_accept;
   logic             ej_drain;

   logic [CNT_W-1:0] inj_cnt;
   logic [CNT_W-1:0] ej_cnt;
   logic             overflow;
   logic             misroute;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign wr_en = bus.i_core_data_val && !full;
   assign rd_en = bus.i_net_en && !empty;

   assign ej_drain  = ej_val && bus.i_core_en;
   assign ej_accept = bus.i_net_data_val && bus.o_net_en;

   assign bus.o_core_en       = !full;
   assign bus.o_net_data      = mem[rd_ptr[AW-1:0]];
   assign bus.o_net_data_val  = !empty;
   assign bus.o_net_en        = !ej_val || bus.i_core_en;
   assign bus.o_core_data     = ej_data;
   assign bus.o_core_data_val = ej_val;
   assign bus.o_inj_count     = inj_cnt;
   assign bus.o_ej_count      = ej_cnt;
   assign bus.o_overflow      = overflow;
   assign bus.o_misroute      = misroute;

   // Packet storage carries no reset; only the valid/pointer state does.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.i_core_data;
   end

   always_ff @(posedge clk) begin
      if (ej_accept) ej_data <= bus.i_net_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ej_val   <= 1'b0;
         inj_cnt  <= '0;
         ej_cnt   <= '0;
         overflow <= 1'b0;
         misroute <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) begin
            rd_ptr  <= rd_ptr + 1'b1;
            inj_cnt <= inj_cnt + 1'b1;
         end
         if (bus.i_core_data_val && full) overflow <= 1'b1;

         if (ej_accept)     ej_val <= 1'b1;
         else if (ej_drain) ej_val <= 1'b0;
         if (ej_drain) ej_cnt <= ej_cnt + 1'b1;
         // Misrouted packets are still delivered; the flag only records the event.
         if (ej_accept && (bus.i_net_data.dest != LOC_ADDR)) misroute <= 1'b1;
      end
   end
endmodule

// File: doc/enoc_core_interface.md
ENOC_CORE_INTERFACE -- requirements
Module: enoc_core_interface

Interface
REQ-001 Parameters: NODES, default 16, total network nodes; LOC, default 0, this node's address; DEPTH, default 4, injection queue entries (power of 2, >=2); CNT_W, default 32, counter width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_core_data  in  packet_t  packet from local core for injection.
REQ-005 i_core_data_val  in  1  validates i_core_data.
REQ-006 o_core_en  out  1  injection queue can accept.
REQ-007 o_net_data  out  packet_t  packet to router core input port.
REQ-008 o_net_data_val  out  1  validates o_net_data.
REQ-009 i_net_en  in  1  router core input port can accept.
REQ-010 i_net_data  in  packet_t  packet from router core output port.
REQ-011 i_net_data_val  in  1  validates i_net_data.
REQ-012 o_net_en  out  1  ejection register can accept.
REQ-013 o_core_data / o_core_data_val  out  packet_t / 1  ejected packet and its valid.
REQ-014 i_core_en  in  1  core can accept ejected packet.
REQ-015 o_inj_count / o_ej_count  out  CNT_W each  packets sent to router / delivered to core.
REQ-016 o_overflow / o_misroute  out  1 each  sticky error flags.

Function
REQ-017 Transfer rule, every port pair: a packet moves in the cycle where valid and enable are both high; valid is never qualified by enable.
REQ-018 Injection queue: DEPTH-entry circular FIFO, read/write pointers of log2(DEPTH)+1 bits, full = MSBs differ and LSBs equal, empty = pointers equal.
REQ-019 o_core_en = not full, combinational from registered pointers; no write pass-through when full, even with a simultaneous read.
REQ-020 First-word-fall-through: o_net_data = head entry, o_net_data_val = not empty; a write into an empty queue appears one cycle later.
REQ-021 Simultaneous write and read at 0 < occupancy < DEPTH: occupancy unchanged, order preserved.
REQ-022 Pointers wrap modulo 2*DEPTH; no entry loss or duplication across wrap.
REQ-023 i_core_data_val high while o_core_en low: packet dropped, queue unchanged, o_overflow set.
REQ-024 Ejection: single-entry register; o_net_en = (register empty) or i_core_en.
REQ-025 Ejection register loads i_net_data on accept; holds while o_core_data_val high and i_core_en low; drain and load in the same cycle sustain one packet per cycle.
REQ-026 Ejection latency: one cycle from accept to o_core_data_val.
REQ-027 o_inj_count increments on each router-side injection transfer; o_ej_count increments on each core-side ejection transfer; both wrap modulo 2^CNT_W without saturation.
REQ-028 Accepted ejected packet with dest != LOC sets o_misroute; the packet is still delivered.
REQ-029 o_overflow and o_misroute clear only on reset.
REQ-030 Packets with dest == LOC are injected normally (loopback handled by router).

Reset
REQ-031 reset_n low asynchronously clears pointers, ejection valid, counters and flags; outputs while low: o_core_en=1, o_net_data_val=0, o_net_en=1, o_core_data_val=0, counts=0, flags=0.
REQ-032 Reset asserted mid-transfer discards all queued and ejecting packets; none reappear after release.
REQ-033 Packet data registers are not reset; data outputs are don't-care while valid is low.
REQ-034 First transfer possible on the first rising edge after reset_n deasserts.

Verification
REQ-035 DEPTH=4, i_net_en=0, inject 5 back-to-back -> 4 accepted, o_core_en low after 4th, 5th dropped, o_overflow=1.
REQ-036 Queue full, i_net_en=1 and i_core_data_val=1 same cycle -> one departs, no write that cycle; next cycle write accepted.
REQ-037 Stream 10 packets in and out with i_net_en=1 -> order preserved across pointer wrap, o_inj_count=10.
REQ-038 Eject dest=LOC with i_core_en toggling 1,0,1 -> packet held during stall, o_net_en low during stall, o_ej_count increments once per delivery.
REQ-039 Eject dest=LOC+1 -> delivered, o_misroute=1 and stays set until reset.
REQ-040 CNT_W=4, 17 injections -> o_inj_count=1; reset_n pulsed low mid-stream -> all outputs return to REQ-031 values within the same cycle.
